ro_power_sequencer: RTL and testbench

Sequences a set of ro_bank instances for controlled power-draw shaping. On a trigger it turns banks on one at a time (thermometer ramp), holds all banks on for a programmable time, then turns them off in reverse order. A cooldown period follows before it re-arms. One ro_enable bit drives each bank; the block never observes the asynchronous bank outputs.

---
 rtl/ro_power_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_ro_power_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ro_power_sequencer.sv
// Ramps a bank of ring oscillators on as a thermometer, holds, ramps off, then cools down.
// Optional macro RO_SEQ_ONTIME_CNT_EN adds a saturating on-time counter output.
module ro_power_sequencer #(
    parameter int NUM_BANKS       = 4,
    parameter int STEP_CYCLES     = 16,
    parameter int HOLD_W          = 16,
    parameter int COOLDOWN_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               trigger_i,
    input  logic                               abort_i,
    input  logic [HOLD_W-1:0]                  hold_cycles_i,
    output logic [NUM_BANKS-1:0]               ro_enable_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [$clog2(NUM_BANKS+1)-1:0]     active_banks_o
`ifdef RO_SEQ_ONTIME_CNT_EN
    ,
    output logic [31:0]                        ontime_cnt_o
`endif
);

    localparam int CNT_W  = $clog2(NUM_BANKS + 1);
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int COOL_W = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;

    localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(STEP_CYCLES - 1);
    localparam logic [COOL_W-1:0] COOL_RELOAD = COOL_W'(COOLDOWN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LAST_BELOW  = CNT_W'(NUM_BANKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RAMP_UP,
        HOLD,
        RAMP_DOWN,
        COOLDOWN
    } state_t;

    state_t                 state_reg;
    logic [STEP_W-1:0]      step_cnt_reg;
    logic [COOL_W-1:0]      cool_cnt_reg;
    logic [HOLD_W-1:0]      hold_reg;
    logic [HOLD_W-1:0]      hold_cnt_reg;
    logic [CNT_W-1:0]       banks_reg;
    logic [NUM_BANKS-1:0]   enable_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   aborted_reg;

    // Enable mask is derived from the bank count so the two can never disagree.
    function automatic logic [NUM_BANKS-1:0] therm(input logic [CNT_W-1:0] n);
        logic [NUM_BANKS-1:0] mask;
        for (int i = 0; i < NUM_BANKS; i++) begin
            mask[i] = (32'(n) > i);
        end
        return mask;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            step_cnt_reg <= '0;
            cool_cnt_reg <= '0;
            hold_reg     <= '0;
            hold_cnt_reg <= '0;
            banks_reg    <= '0;
            enable_reg   <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            aborted_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (trigger_i && !abort_i) begin
                        hold_reg     <= hold_cycles_i;
                        aborted_reg  <= 1'b0;
                        busy_reg     <= 1'b1;
                        banks_reg    <= CNT_W'(1);
                        enable_reg   <= therm(CNT_W'(1));
                        step_cnt_reg <= STEP_RELOAD;
                        if (NUM_BANKS == 1) begin
                            if (hold_cycles_i != '0) begin
                                state_reg    <= HOLD;
                                hold_cnt_reg <= hold_cycles_i - HOLD_W'(1);
                            end else begin
                                state_reg <= RAMP_DOWN;
                            end
                        end else begin
                            state_reg <= RAMP_UP;
                        end
                    end
                end

                RAMP_UP, HOLD, RAMP_DOWN: begin
                    if (abort_i) begin
                        state_reg    <= COOLDOWN;
                        cool_cnt_reg <= COOL_RELOAD;
                        step_cnt_reg <= STEP_RELOAD;
                        banks_reg    <= '0;
                        enable_reg   <= '0;
                        aborted_reg  <= 1'b1;
                    end else if (state_reg == RAMP_UP) begin
                        if (step_cnt_reg == '0) begin
                            step_cnt_reg <= STEP_RELOAD;
                            banks_reg    <= banks_reg + CNT_W'(1);
                            enable_reg   <= therm(banks_reg + CNT_W'(1));
                            if (banks_reg == LAST_BELOW) begin
                                // Zero hold skips HOLD entirely on the same edge.
                                if (hold_reg != '0) begin
                                    state_reg    <= HOLD;
                                    hold_cnt_reg <= hold_reg - HOLD_W'(1);
                                end else begin
                                    state_reg <= RAMP_DOWN;
                                end
                            end
                        end else begin
                            step_cnt_reg <= step_cnt_reg - STEP_W'(1);
                        end
                    end else if (state_reg == HOLD) begin
                        if (hold_cnt_reg == '0) begin
                            state_reg    <= RAMP_DOWN;
                            step_cnt_reg <= STEP_RELOAD;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - HOLD_W'(1);
                        end
                    end else begin
                        if (step_cnt_reg == '0) begin
                            step_cnt_reg <= STEP_RELOAD;
                            banks_reg    <= banks_reg - CNT_W'(1);
                            enable_reg   <= therm(banks_reg - CNT_W'(1));
                            if (banks_reg == CNT_W'(1)) begin
                                state_reg    <= COOLDOWN;
                                cool_cnt_reg <= COOL_RELOAD;
                            end
                        end else begin
                            step_cnt_reg <= step_cnt_reg - STEP_W'(1);
                        end
                    end
                end

                COOLDOWN: begin
                    // Triggers and aborts are deliberately ignored while cooling down.
                    if (cool_cnt_reg == '0) begin
                        state_reg    <= IDLE;
                        busy_reg     <= 1'b0;
                        done_reg     <= !aborted_reg;
                        step_cnt_reg <= STEP_RELOAD;
                    end else begin
                        cool_cnt_reg <= cool_cnt_reg - COOL_W'(1);
                    end
                end

                default: begin
                    state_reg  <= IDLE;
                    busy_reg   <= 1'b0;
                    banks_reg  <= '0;
                    enable_reg <= '0;
                end
            endcase
        end
    end

    assign ro_enable_o    = enable_reg;
    assign active_banks_o = banks_reg;
    assign busy_o         = busy_reg;
    assign done_o         = done_reg;

`ifdef RO_SEQ_ONTIME_CNT_EN
    logic [31:0] ontime_cnt_reg;

    // Accumulates across sequences; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ontime_cnt_reg <= '0;
        end else if (enable_reg != '0 && ontime_cnt_reg != 32'hFFFF_FFFF) begin
            ontime_cnt_reg <= ontime_cnt_reg + 32'd1;
        end
    end

    assign ontime_cnt_o = ontime_cnt_reg;
`endif

endmodule

// File: tb/tb_ro_power_sequencer.sv
// Directed plus random stimulus for ro_power_sequencer, checked every cycle against
// a timeline model that computes bank count from the trigger time and hold value.
module tb_ro_power_sequencer;

    localparam int N = 4;
    localparam int S = 16;
    localparam int C = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trigger_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] hold_cycles_i = '0;
    logic [3:0]  ro_enable_o;
    logic        busy_o;
    logic        done_o;
    logic [2:0]  active_banks_o;
`ifdef RO_SEQ_ONTIME_CNT_EN
    logic [31:0] ontime_cnt_o;
`endif

    always #5 clk = ~clk;

    ro_power_sequencer #(
        .NUM_BANKS(N), .STEP_CYCLES(S), .HOLD_W(16), .COOLDOWN_CYCLES(C)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .trigger_i(trigger_i),
        .abort_i(abort_i),
        .hold_cycles_i(hold_cycles_i),
        .ro_enable_o(ro_enable_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .active_banks_o(active_banks_o)
`ifdef RO_SEQ_ONTIME_CNT_EN
        ,
        .ontime_cnt_o(ontime_cnt_o)
`endif
    );

    int     n_vec = 0;
    int     n_miss = 0;
    int     edge_idx = 0;
    bit     in_seq = 0;
    bit     aborted_m = 0;
    int     t_start = 0;
    int     h_m = 0;
    int     cool_start = 0;
    int     idle_at = 0;
    int     exp_count = 0;
    bit     exp_done = 0;
    longint exp_ontime = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", tag, edge_idx, obs, exp);
        end
    endtask

    // Banks lit after edge e of a sequence triggered at t_start, by the timeline rules.
    function automatic int count_at(input int e);
        int d, up, k;
        d  = e - t_start;
        up = (N - 1) * S;
        if (d <= up) return d / S + 1;
        if (d < up + h_m) return N;
        k = (d - up - h_m) / S;
        return (k < N) ? N - k : 0;
    endfunction

    task automatic tick(input bit rn, input bit tr, input bit ab, input int hold);
        rst_n         = rn;
        trigger_i     = tr;
        abort_i       = ab;
        hold_cycles_i = 16'(hold);
        edge_idx++;
        if (!rn) begin
            in_seq     = 0;
            exp_count  = 0;
            exp_done   = 0;
            exp_ontime = 0;
        end else begin
            if (exp_count != 0 && exp_ontime != 64'hFFFF_FFFF) exp_ontime++;
            exp_done = 0;
            if (!in_seq) begin
                if (tr && !ab) begin
                    in_seq     = 1;
                    aborted_m  = 0;
                    t_start    = edge_idx;
                    h_m        = hold;
                    cool_start = t_start + (N - 1) * S + h_m + N * S;
                    idle_at    = cool_start + C;
                    exp_count  = 1;
                    $display("seq start edge %0d hold %0d", edge_idx, hold);
                end
            end else if (edge_idx == idle_at) begin
                in_seq    = 0;
                exp_done  = !aborted_m;
                exp_count = 0;
                $display("seq end edge %0d aborted %0d", edge_idx, aborted_m);
            end else if (!aborted_m && ab && edge_idx <= cool_start) begin
                aborted_m = 1;
                idle_at   = edge_idx + C;
                exp_count = 0;
            end else begin
                exp_count = aborted_m ? 0 : count_at(edge_idx);
            end
        end
        @(negedge clk);
        check_val("ro_enable", 32'(ro_enable_o), 32'((1 << exp_count) - 1));
        check_val("active_banks", 32'(active_banks_o), 32'(exp_count));
        check_val("busy", 32'(busy_o), 32'(in_seq));
        check_val("done", 32'(done_o), 32'(exp_done));
`ifdef RO_SEQ_ONTIME_CNT_EN
        check_val("ontime", ontime_cnt_o, 32'(exp_ontime));
`endif
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
    endtask

    initial begin
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 5);
        idle_ticks(3);

        // Nominal sequence run twice, then zero hold.
        tick(1, 1, 0, 100);
        idle_ticks(290);
        tick(1, 1, 0, 100);
        idle_ticks(290);
        tick(1, 1, 0, 0);
        idle_ticks(190);

        // Abort while three banks are lit.
        tick(1, 1, 0, 100);
        idle_ticks(39);
        tick(1, 0, 1, 0);
        idle_ticks(80);

        // Triggers while busy, then trigger together with abort in idle.
        tick(1, 1, 0, 20);
        idle_ticks(9);
        tick(1, 1, 0, 7);
        idle_ticks(140);
        tick(1, 1, 0, 9);
        idle_ticks(60);
        tick(1, 1, 1, 30);
        idle_ticks(20);

        // Reset in the middle of HOLD, then a fresh sequence.
        tick(1, 1, 0, 100);
        idle_ticks(60);
        tick(0, 0, 0, 0);
        idle_ticks(5);
        tick(1, 1, 0, 10);
        idle_ticks(210);

        for (int i = 0; i < 5000; i++) begin
            tick(($urandom_range(0, 1999) != 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 299) == 0),
                 int'($urandom_range(0, 40)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
